// File: rtl/prime_pkg.sv
// Shared definitions for the prime-search scan controller and its trial divider.
// Ports: none (package). Provides WIDTH, the value type, FSM state codes and the
// first candidate constant.
package prime_pkg;

  localparam int WIDTH = 11;

  typedef logic [WIDTH-1:0] val_t;

  // FSM state encodings, kept as plain constants for legacy tool flows
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TEST = 3'd1;
  localparam logic [2:0] ST_EMIT = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int   FIRST_CAND   = 2;
  localparam val_t FIRST_CAND_V = val_t'(FIRST_CAND);

endpackage

// File: rtl/prime_scan_ctrl_if.sv
// Host-side bundle of the prime scan controller: launch, status and prime stream.
// Ports: master = host (drives start/num_max/prime_ready), slave = controller
// (drives busy/done/prime_valid/prime/number_checked/number_of_primes).
interface prime_scan_ctrl_if;
  import prime_pkg::*;

  logic start;
  val_t num_max;
  logic busy;
  logic done;
  logic prime_valid;
  logic prime_ready;
  val_t prime;
  val_t number_checked;
  val_t number_of_primes;

  modport master (
    output start, num_max, prime_ready,
    input  busy, done, prime_valid, prime, number_checked, number_of_primes
  );

  modport slave (
    input  start, num_max, prime_ready,
    output busy, done, prime_valid, prime, number_checked, number_of_primes
  );

endinterface

// File: rtl/prime_trial_div.sv
// Trial-division checker: tests one divisor d of cand per cycle.
// Latency: verdict is combinational on the current d; d advances one step per cycle.
// Backpressure: none; the controller holds cand and only steps d while unresolved.
// Ports: clk, rst (sync, active-high); init loads d=2; step increments d;
// cand is the value under test; is_prime / is_comp / resolved report the verdict.
module prime_trial_div
  import prime_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic step,
  input  val_t cand,
  output logic is_prime,
  output logic is_comp,
  output logic resolved
);

  val_t                 d;
  logic [2*WIDTH-1:0]   d_sq;
  val_t                 rem;
  logic                 d_nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
    end else if (init) begin
      d <= FIRST_CAND_V;
    end else if (step) begin
      d <= d + val_t'(1);
    end
  end

  always_comb begin
    // Square at double width so d*d can never wrap for any d
    d_sq     = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    d_nz     = (d != '0);
    // d is only zero straight after reset; avoid a divide by zero there
    rem      = d_nz ? (cand % d) : cand;
    is_prime = (d_sq > {{WIDTH{1'b0}}, cand});
    is_comp  = !is_prime && d_nz && (rem == '0);
    resolved = is_prime || is_comp;
  end

endmodule

// File: rtl/prime_scan_ctrl.sv
// Prime scan controller: walks candidates 2..num_max through trial division and
// streams every prime found; start/busy/done launch handshake.
// Latency: busy the cycle after start; per candidate = test cycles + 1 NEXT + EMIT.
// Backpressure: prime_valid/prime hold in EMIT until prime_ready; scan stalls meanwhile.
// Ports: clk, rst (sync, active-high), bus (prime_scan_ctrl_if.slave).
// Build option: PRIME_SCAN_ODD_SKIP_EN skips even candidates after 2.
module prime_scan_ctrl
  import prime_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  prime_scan_ctrl_if.slave   bus
);

  logic [2:0]     state;
  val_t           lim;
  val_t           cand;
  val_t           prime_q;
  val_t           checked_q;
  val_t           count_q;

  logic           td_init;
  logic           td_step;
  logic           td_is_prime;
  logic           td_is_comp;
  logic           td_resolved;

  // One extra bit so the step past lim = 2^WIDTH-1 is seen, not wrapped
  logic [WIDTH:0] next_cand;
  logic           last_cand;

  prime_trial_div u_trial_div (
    .clk      (clk),
    .rst      (rst),
    .init     (td_init),
    .step     (td_step),
    .cand     (cand),
    .is_prime (td_is_prime),
    .is_comp  (td_is_comp),
    .resolved (td_resolved)
  );

  always_comb begin
`ifdef PRIME_SCAN_ODD_SKIP_EN
    // 2 -> 3, then odd values only
    if (cand == FIRST_CAND_V) begin
      next_cand = {1'b0, cand} + (WIDTH+1)'(1);
    end else begin
      next_cand = {1'b0, cand} + (WIDTH+1)'(2);
    end
`else
    next_cand = {1'b0, cand} + (WIDTH+1)'(1);
`endif
    last_cand = (next_cand > {1'b0, lim});
  end

  // Divisor restarts at 2 on launch and on every move to a new candidate
  always_comb begin
    td_init = 1'b0;
    td_step = 1'b0;
    case (state)
      ST_IDLE: td_init = bus.start;
      ST_TEST: td_step = !td_resolved;
      ST_NEXT: td_init = !last_cand;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lim       <= '0;
      cand      <= '0;
      prime_q   <= '0;
      checked_q <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            lim       <= bus.num_max;
            cand      <= FIRST_CAND_V;
            prime_q   <= '0;
            checked_q <= '0;
            count_q   <= '0;
            state     <= (bus.num_max < FIRST_CAND_V) ? ST_DONE : ST_TEST;
          end
        end
        ST_TEST: begin
          if (td_is_prime) begin
            checked_q <= cand;
            prime_q   <= cand;
            state     <= ST_EMIT;
          end else if (td_is_comp) begin
            checked_q <= cand;
            state     <= ST_NEXT;
          end
        end
        ST_EMIT: begin
          if (bus.prime_ready) begin
            count_q <= count_q + val_t'(1);
            state   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_cand) begin
            state <= ST_DONE;
          end else begin
            cand  <= next_cand[WIDTH-1:0];
            state <= ST_TEST;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy             = (state == ST_TEST) || (state == ST_EMIT) || (state == ST_NEXT);
  assign bus.done             = (state == ST_DONE);
  assign bus.prime_valid      = (state == ST_EMIT);
  assign bus.prime            = prime_q;
  assign bus.number_checked   = checked_q;
  assign bus.number_of_primes = count_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Self-checking bench for prime_scan_ctrl: a number-theory model (prime list,
// per-candidate divisor counts, latency) is checked every cycle of a scan.
module tb_prime_scan_ctrl;
  import prime_pkg::*;

  logic clk;
  logic rst;
  prime_scan_ctrl_if bus ();

  prime_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // model / scoreboard state
  int   exp_q[$];
  int   model_cnt;
  int   exp_lat;
  int   exp_checked;
  int   exp_last;
  int   cur_lim;
  int   cyc;
  int   stalls;
  bit   active    = 1'b0;
  bit   post_done = 1'b0;
  bit   prev_hs   = 1'b0;

  // ready stimulus control
  int   rdy_pct    = 100;
  int   stall_val  = 0;
  int   stall_left = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime_f(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // cycles spent testing c: divisors 2..d tried, d being the first that decides
  function automatic int test_cycles(input int c);
    int k = 2;
    while (!(k * k > c) && (c % k != 0)) k++;
    return k - 1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_valid"},   bus.prime_valid, 0);
    check({tag, "_prime"},   bus.prime, 0);
    check({tag, "_checked"}, bus.number_checked, 0);
    check({tag, "_count"},   bus.number_of_primes, 0);
  endtask

  task automatic launch(input int lim);
    int c;
    int lat;
    exp_q.delete();
    model_cnt   = 0;
    exp_checked = 0;
    exp_last    = 0;
    cur_lim     = lim;
    lat         = 0;
    c           = 2;
    while (lim >= 2 && c <= lim) begin
      lat += test_cycles(c) + 1 + (is_prime_f(c) ? 1 : 0);
      if (is_prime_f(c)) begin
        exp_q.push_back(c);
        exp_last = c;
      end
      exp_checked = c;
`ifdef PRIME_SCAN_ODD_SKIP_EN
      c = (c == 2) ? 3 : c + 2;
`else
      c = c + 1;
`endif
    end
    exp_lat = 1 + lat;
    @(posedge clk);
    #1;
    bus.num_max = val_t'(lim);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc       = 0;
    stalls    = 0;
    prev_hs   = 1'b0;
    post_done = 1'b0;
    active    = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (active && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (active) begin
      total++;
      bad++;
      $display("FAIL timeout lim=%0d waited=%0d cycles", cur_lim, n);
      active = 1'b0;
    end
    #1;
  endtask

  // ready driver: random acceptance, with forced stalls on a chosen prime
  initial begin
    bus.prime_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.prime_valid && int'(bus.prime) == stall_val) begin
        bus.prime_ready = 1'b0;
        stall_left--;
      end else begin
        bus.prime_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (active) begin
        cyc++;
        check("done_with_valid", bus.done && bus.prime_valid, 0);
        check("count", bus.number_of_primes, model_cnt);
        if (post_done) begin
          check("done_one_cycle", bus.done, 0);
          check("busy_after_done", bus.busy, 0);
          active    = 1'b0;
          post_done = 1'b0;
        end else begin
          check("busy", bus.busy, (cur_lim >= 2) && !bus.done);
          if (bus.prime_valid) begin
            check("back_to_back_valid", prev_hs, 0);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL extra_prime got=%0d want=none", bus.prime);
            end else begin
              check("prime", bus.prime, exp_q[0]);
            end
            if (bus.prime_ready) begin
              if (exp_q.size() > 0) void'(exp_q.pop_front());
              model_cnt++;
              prev_hs = 1'b1;
            end else begin
              stalls++;
              prev_hs = 1'b0;
            end
          end else begin
            prev_hs = 1'b0;
          end
          if (bus.done) begin
            check("latency", cyc, exp_lat + stalls);
            check("checked", bus.number_checked, exp_checked);
            check("primes_left", exp_q.size(), 0);
            check("last_prime", bus.prime, exp_last);
            post_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int lim;
    int n;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.num_max = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // hand-computed divisor counts pin the latency model
    check("model_tc2",  test_cycles(2), 1);
    check("model_tc4",  test_cycles(4), 1);
    check("model_tc9",  test_cycles(9), 2);
    check("model_tc25", test_cycles(25), 4);

    // lim=10, always ready
    launch(10);
    wait_done(2000);
    check("s1_count", bus.number_of_primes, 4);
`ifdef PRIME_SCAN_ODD_SKIP_EN
    check("s1_checked", bus.number_checked, 9);
`else
    check("s1_checked", bus.number_checked, 10);
`endif

    // lim below the first candidate
    launch(1);
    wait_done(100);
    check("s2_count", bus.number_of_primes, 0);
    check("s2_checked", bus.number_checked, 0);

    // stall five cycles on prime 3
    stall_val  = 3;
    stall_left = 5;
    launch(20);
    wait_done(4000);
    check("s3_count", bus.number_of_primes, 8);
    check("s3_stalls_used", stall_left, 0);

    // start reissued mid-scan must be ignored
    launch(30);
    repeat (15) @(posedge clk);
    #1;
    bus.num_max = val_t'(3);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(6000);
    check("s6_count", bus.number_of_primes, 10);

    // randomized limits and acceptance
    for (int i = 0; i < 6; i++) begin
      rdy_pct = $urandom_range(30, 100);
      lim     = $urandom_range(0, 150);
      launch(lim);
      wait_done(20000);
    end
    rdy_pct = 100;

    // reset while prime 5 is waiting in EMIT
    stall_val  = 5;
    stall_left = 100000;
    launch(10);
    n = 0;
    while (!(bus.prime_valid && bus.prime == val_t'(5)) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("s5_reached_prime5", bus.prime_valid && bus.prime == val_t'(5), 1);
    @(posedge clk);
    #1;
    active = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    stall_left = 0;
    launch(10);
    wait_done(2000);
    check("s5_count", bus.number_of_primes, 4);

    // full-range limit, no wrap-around
    launch(2047);
    wait_done(60000);
    check("s4_count", bus.number_of_primes, 309);
    check("s4_checked", bus.number_checked, 2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
